// File: rtl/sw_pkg.sv
// Shared types for the sequence feeder: base code, FSM states, pointer width helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sw_pkg;

    typedef logic [1:0] base_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        S_OFFER  = 3'd1,
        T_STREAM = 3'd2,
        WB_WAIT  = 3'd3,
        SWAP     = 3'd4
    } state_t;

    // Address width for a memory of 'depth' entries (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of a counter that must hold the value 'depth' itself.
    function automatic int len_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sequence_feeder_if.sv
// Host-side bundle of the sequence feeder: load, control, s-chunk, t-stream and write-back.
// Latency: n/a (wires only).
// Backpressure: i_update_s_w / i_update_t_w act as the consumer's ready strobes.
interface sequence_feeder_if #(
    parameter int PE_ARRAY_SIZE = 8,
    parameter int VEF_BIT       = 16
);
    import sw_pkg::*;

    // load
    logic                       i_load_valid;
    logic                       i_load_sel;
    base_t                      i_load_base;
    logic                       o_load_ready;
    // control
    logic                       i_start;
    logic                       o_busy;
    logic                       o_err;
    // s side
    logic                       o_data_valid;
    logic                       i_update_s_w;
    logic [PE_ARRAY_SIZE*2-1:0] o_s;
    logic                       o_s_last;
    // t side
    logic                       i_update_t_w;
    base_t                      o_t;
    logic [VEF_BIT-1:0]         o_v;
    logic [VEF_BIT-1:0]         o_f;
    logic                       o_t_last;
    // write-back
    logic                       i_wb_valid;
    base_t                      i_t;
    logic [VEF_BIT-1:0]         i_v;
    logic [VEF_BIT-1:0]         i_f;

    modport master (
        output i_load_valid, i_load_sel, i_load_base, i_start,
               i_update_s_w, i_update_t_w, i_wb_valid, i_t, i_v, i_f,
        input  o_load_ready, o_busy, o_err, o_data_valid, o_s, o_s_last,
               o_t, o_v, o_f, o_t_last
    );

    modport slave (
        input  i_load_valid, i_load_sel, i_load_base, i_start,
               i_update_s_w, i_update_t_w, i_wb_valid, i_t, i_v, i_f,
        output o_load_ready, o_busy, o_err, o_data_valid, o_s, o_s_last,
               o_t, o_v, o_f, o_t_last
    );

endinterface

// File: rtl/sw_pingpong_buf.sv
// Two-bank t-entry store {t,v,f}: one bank is streamed out while the other collects write-backs.
// Latency: 1 cycle from rd_addr to rd_dat; writes land on the next edge.
// Backpressure: none; the owner holds rd_addr to hold rd_dat.
module sw_pingpong_buf import sw_pkg::*; #(
    parameter int T_MAX   = 1024,
    parameter int VEF_BIT = 16,
    localparam int AW     = ptr_w(T_MAX),
    localparam int DW     = 2 + 2*VEF_BIT
) (
    input  logic          clk,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat
);

    logic [DW-1:0] bank0 [T_MAX];
    logic [DW-1:0] bank1 [T_MAX];

    // Single write port steered to either bank; registered read from the selected bank.
    always_ff @(posedge clk) begin
        if (wr_en && !wr_bank) bank0[wr_addr] <= wr_dat;
        if (wr_en &&  wr_bank) bank1[wr_addr] <= wr_dat;
        rd_dat <= rd_bank ? bank1[rd_addr] : bank0[rd_addr];
    end

endmodule

// File: rtl/sequence_feeder.sv
// Feeds s in PE-sized chunks and streams t/v/f per chunk, collecting write-backs for the next pass (optional SEQ_FEEDER_WB_CHECK_EN flags dropped write-backs on o_err).
// Latency: t entry presented 1 cycle after i_update_t_w; first entry ready on entering T_STREAM.
// Backpressure: o_s/o_t/o_v/o_f hold until i_update_s_w / i_update_t_w; loads accepted only in IDLE.
module sequence_feeder import sw_pkg::*; #(
    parameter int PE_ARRAY_SIZE = 8,
    parameter int VEF_BIT       = 16,
    parameter int S_MAX         = 256,
    parameter int T_MAX         = 1024
) (
    input  logic              clk,
    input  logic              rst,
    sequence_feeder_if.slave  bus
);

    localparam int P   = PE_ARRAY_SIZE;
    localparam int SAW = ptr_w(S_MAX);
    localparam int SLW = len_w(S_MAX);
    localparam int TAW = ptr_w(T_MAX);
    localparam int TLW = len_w(T_MAX);
    localparam int DW  = 2 + 2*VEF_BIT;

    localparam logic [SLW-1:0] S_MAX_L = SLW'(S_MAX);
    localparam logic [TLW-1:0] T_MAX_L = TLW'(T_MAX);

    state_t          state, state_nxt;
    logic [SLW-1:0]  s_len;
    logic [TLW-1:0]  t_len;
    logic [SLW-1:0]  k;
    logic [TLW-1:0]  wb_cnt;
    logic [TLW-1:0]  wb_cnt_nxt;
    logic [TAW-1:0]  rd_ptr;
    logic            bank;
    base_t           s_mem [S_MAX];

    logic            load_s, load_t, start_acc;
    logic            s_last, t_last, upd_t, wb_take;
    logic [TAW-1:0]  rd_addr;
    logic [DW-1:0]   rd_dat;
    logic            wr_en, wr_bank;
    logic [TAW-1:0]  wr_addr;
    logic [DW-1:0]   wr_dat;
    logic [P*2-1:0]  s_chunk;
    int              s_idx;

    assign load_s    = (state == IDLE) && bus.i_load_valid && !bus.i_load_sel && (s_len < S_MAX_L);
    assign load_t    = (state == IDLE) && bus.i_load_valid &&  bus.i_load_sel && (t_len < T_MAX_L);
    assign start_acc = (state == IDLE) && bus.i_start && (s_len != '0) && (t_len != '0);

    // The current chunk is the last one once it reaches or passes the end of s.
    assign s_last  = ((int'(k) + 1) * P) >= int'(s_len);
    assign t_last  = (state == T_STREAM) && ((TLW'(rd_ptr) + TLW'(1)) == t_len);
    assign upd_t   = (state == T_STREAM) && bus.i_update_t_w;

    // Write-backs only count during a non-final pass and only up to t_len entries.
    assign wb_take    = bus.i_wb_valid && ((state == T_STREAM) || (state == WB_WAIT))
                        && !s_last && (wb_cnt < t_len);
    assign wb_cnt_nxt = wb_take ? (wb_cnt + TLW'(1)) : wb_cnt;

    // Look one entry ahead on a consume so the next entry appears on the following cycle.
    assign rd_addr = (upd_t && !t_last) ? (rd_ptr + TAW'(1)) : rd_ptr;

    // Loads go to the bank being read; write-backs go to the other one.
    assign wr_en   = load_t || wb_take;
    assign wr_bank = load_t ? bank : ~bank;
    assign wr_addr = load_t ? t_len[TAW-1:0] : wb_cnt[TAW-1:0];
    assign wr_dat  = load_t ? {bus.i_load_base, {(2*VEF_BIT){1'b0}}}
                            : {bus.i_t, bus.i_v, bus.i_f};

    sw_pingpong_buf #(
        .T_MAX   (T_MAX),
        .VEF_BIT (VEF_BIT)
    ) u_buf (
        .clk     (clk),
        .rd_bank (bank),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat),
        .wr_en   (wr_en),
        .wr_bank (wr_bank),
        .wr_addr (wr_addr),
        .wr_dat  (wr_dat)
    );

    // s storage: append-only while idle, no reset needed since reads are gated by s_len.
    always_ff @(posedge clk) begin
        if (load_s) s_mem[s_len[SAW-1:0]] <= bus.i_load_base;
    end

    // Gather chunk k, PE 0 in the top slice, padding past the end of s with 2'b00.
    always_comb begin
        s_chunk = '0;
        s_idx   = 0;
        for (int j = 0; j < P; j++) begin
            s_idx = int'(k) * P + j;
            if (s_idx < int'(s_len)) s_chunk[(P-j)*2-1 -: 2] = s_mem[s_idx[SAW-1:0]];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_acc) state_nxt = S_OFFER;
            S_OFFER:  if (bus.i_update_s_w) state_nxt = T_STREAM;
            T_STREAM: if (upd_t && t_last) state_nxt = s_last ? IDLE : WB_WAIT;
            WB_WAIT:  if (wb_cnt_nxt == t_len) state_nxt = SWAP;
            SWAP:     state_nxt = S_OFFER;
            default:  state_nxt = IDLE;
        endcase
    end

    // Lengths, chunk index, write-back count, read pointer and bank select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_len  <= '0;
            t_len  <= '0;
            k      <= '0;
            wb_cnt <= '0;
            rd_ptr <= '0;
            bank   <= 1'b0;
        end else begin
            if (load_s) s_len <= s_len + SLW'(1);
            if (load_t) t_len <= t_len + TLW'(1);
            if (wb_take) wb_cnt <= wb_cnt_nxt;
            case (state)
                IDLE: if (start_acc) begin
                    k      <= '0;
                    wb_cnt <= '0;
                    rd_ptr <= '0;
                end
                T_STREAM: if (upd_t && !t_last) rd_ptr <= rd_ptr + TAW'(1);
                SWAP: begin
                    bank   <= ~bank;
                    k      <= k + SLW'(1);
                    wb_cnt <= '0;
                    rd_ptr <= '0;
                end
                default: ;
            endcase
        end
    end

    // Output decode: everything except o_load_ready is quiet outside an active pass.
    always_comb begin
        bus.o_load_ready = (state == IDLE);
        bus.o_busy       = (state != IDLE);
        bus.o_data_valid = (state == S_OFFER) || (state == T_STREAM);
        bus.o_s          = bus.o_data_valid ? s_chunk : '0;
        bus.o_s_last     = bus.o_data_valid && s_last;
        bus.o_t          = '0;
        bus.o_v          = '0;
        bus.o_f          = '0;
        bus.o_t_last     = t_last;
        if (state == T_STREAM) begin
            bus.o_t = rd_dat[DW-1 -: 2];
            bus.o_v = rd_dat[2*VEF_BIT-1 -: VEF_BIT];
            bus.o_f = rd_dat[VEF_BIT-1:0];
        end
    end

`ifdef SEQ_FEEDER_WB_CHECK_EN
    logic err_q;

    // Sticky flag for any write-back that was not stored; an accepted start clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              err_q <= 1'b0;
        else if (bus.i_wb_valid && !wb_take)  err_q <= 1'b1;
        else if (start_acc)                   err_q <= 1'b0;
    end

    assign bus.o_err = err_q;
`else
    assign bus.o_err = 1'b0;
`endif

endmodule
